// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath, with a variable-latency memory handshake.
// Optional trap on illegal instructions: define MIPS_CTRL_ILLEGAL_TRAP_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       ext_mode,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_IEXEC  = 4'd11,
    ST_IWB    = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state_q, state_nx;
  logic       op_known, fn_known, legal;
  logic [3:0] r_alu, i_alu;
  logic [1:0] ext_dec;

  // Instruction decode; opcode/funct come straight from IR, which is stable after FETCH.
  always_comb begin
    op_known = 1'b1;
    i_alu    = ALU_ADD;
    ext_dec  = 2'b00;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_SLTI: ;
      OP_ANDI: begin i_alu = ALU_AND; ext_dec = 2'b01; end
      OP_ORI:  begin i_alu = ALU_OR;  ext_dec = 2'b01; end
      OP_LUI:  begin i_alu = ALU_OR;  ext_dec = 2'b10; end
      default: op_known = 1'b0;
    endcase
    if (opcode == OP_SLTI) i_alu = ALU_SLT;

    fn_known = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      6'b100111: r_alu = ALU_NOR;
      default:   fn_known = 1'b0;
    endcase
    legal = op_known && ((opcode != OP_RTYPE) || fn_known);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RST;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx   = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_AND;
    ext_mode   = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    if (state_q != ST_RST && state_q != ST_TRAP) ext_mode = ext_dec;
    case (state_q)
      ST_RST: state_nx = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        if (!legal) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          state_nx = ST_TRAP;
`else
          state_nx   = ST_FETCH;
          instr_done = 1'b1;
`endif
        end else begin
          case (opcode)
            OP_RTYPE:      state_nx = ST_EXEC;
            OP_LW, OP_SW:  state_nx = ST_MEMADR;
            OP_BEQ, OP_BNE: state_nx = ST_BRANCH;
            OP_J:          state_nx = ST_JUMP;
            default:       state_nx = ST_IEXEC;
          endcase
        end
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
        state_nx  = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nx = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        state_nx  = ST_RWB;
      end
      ST_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_source  = 2'b01;
        pc_en      = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_source  = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = i_alu;
        state_nx  = ST_IWB;
      end
      ST_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_TRAP: state_nx = ST_TRAP;
      default: state_nx = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal_q <= 1'b0;
    else if (state_nx == ST_TRAP) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed cases plus random instruction streams
// checked against a per-instruction state-path model.
module tb_mips_multicycle_ctrl;

  logic        clk, rst_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_en;
  logic [1:0]  pc_source, alu_src_b, ext_mode;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal;
  logic [3:0]  alu_ctrl, state;
  logic [31:0] retired;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .ext_mode(ext_mode), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal),
    .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs_vec;
  assign obs_vec = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                    alu_src_b, alu_ctrl, ext_mode, reg_dst, mem_to_reg, reg_write, instr_done};

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {int st; logic rdy;} step_t;
  step_t       path[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_ret = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Instruction class: 0 lw, 1 sw, 2 R-type, 3 branch, 4 jump, 5 I-type ALU, 6 illegal
  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                    6'b101010, 6'b100111}) ? 2 : 6;
      6'b000100, 6'b000101: return 3;
      6'b000010: return 4;
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      6'b001100: return 4'b0000;
      6'b001101, 6'b001111: return 4'b0001;
      6'b001010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected control word for one cycle, taken from the per-state output table.
  function automatic logic [19:0] exp_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input logic rdy);
    logic mr, mw, iod, irw, pce, asa, rd, m2r, rw, done;
    logic [1:0] ps, asb, em;
    logic [3:0] ac;
    {mr, mw, iod, irw, pce, asa, rd, m2r, rw, done} = '0;
    ps = '0; asb = '0; em = '0; ac = '0;
    if (st != 0 && st != 13)
      em = (op == 6'b001100 || op == 6'b001101) ? 2'b01 : (op == 6'b001111) ? 2'b10 : 2'b00;
    case (st)
      1:  begin mr = 1; asb = 2'b01; ac = 4'b0010; irw = rdy; pce = rdy; end
      2:  begin asb = 2'b11; ac = 4'b0010; done = (cls(op, fn) == 6) && !TRAP_EN; end
      3:  begin asa = 1; asb = 2'b10; ac = 4'b0010; end
      4:  begin mr = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; done = 1; end
      6:  begin mw = 1; iod = 1; done = rdy; end
      7:  begin asa = 1; ac = fn_alu(fn); end
      8:  begin rw = 1; rd = 1; done = 1; end
      9:  begin asa = 1; ac = 4'b0110; ps = 2'b01; pce = (op == 6'b000100) ? z : !z; done = 1; end
      10: begin ps = 2'b10; pce = 1; done = 1; end
      11: begin asa = 1; asb = 2'b10; ac = imm_alu(op); end
      12: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {mr, mw, iod, irw, pce, ps, asa, asb, ac, em, rd, m2r, rw, done};
  endfunction

  // Runs one instruction from FETCH: fw wait cycles in FETCH, mw in the data access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int c, irw_cnt, done_at, want_len;
    int base [7] = '{5, 4, 4, 3, 3, 4, 2};
    c = cls(op, fn);
    path.delete();
    for (int i = 0; i < fw; i++) path.push_back('{st: 1, rdy: 1'b0});
    path.push_back('{st: 1, rdy: 1'b1});
    path.push_back('{st: 2, rdy: 1'($urandom_range(0, 1))});
    case (c)
      0: begin
        path.push_back('{st: 3, rdy: 1'($urandom_range(0, 1))});
        for (int i = 0; i < mw; i++) path.push_back('{st: 4, rdy: 1'b0});
        path.push_back('{st: 4, rdy: 1'b1});
        path.push_back('{st: 5, rdy: 1'($urandom_range(0, 1))});
      end
      1: begin
        path.push_back('{st: 3, rdy: 1'($urandom_range(0, 1))});
        for (int i = 0; i < mw; i++) path.push_back('{st: 6, rdy: 1'b0});
        path.push_back('{st: 6, rdy: 1'b1});
      end
      2: begin path.push_back('{st: 7, rdy: 1'b1}); path.push_back('{st: 8, rdy: 1'b0}); end
      3: path.push_back('{st: 9, rdy: 1'($urandom_range(0, 1))});
      4: path.push_back('{st: 10, rdy: 1'($urandom_range(0, 1))});
      5: begin path.push_back('{st: 11, rdy: 1'b0}); path.push_back('{st: 12, rdy: 1'b1}); end
      default: ;
    endcase
    irw_cnt = 0;
    done_at = -1;
    foreach (path[i]) begin
      mem_ready = path[i].rdy;
      opcode = op; funct = fn; zero = z;
      #4;
      chk("state", 32'(state), 32'(path[i].st));
      chk("ctrl", 32'(obs_vec), 32'(exp_out(path[i].st, op, fn, z, path[i].rdy)));
      chk("illegal_low", 32'(illegal), 32'd0);
      if (ir_write) irw_cnt++;
      if (instr_done && done_at < 0) done_at = i + 1;
      @(posedge clk); #1;
    end
    chk("ir_write_once", irw_cnt, 1);
    if (!(c == 6 && TRAP_EN)) begin
      want_len = base[c] + fw + ((c == 0 || c == 1) ? mw : 0);
      chk("cycles", done_at, want_len);
      exp_ret = exp_ret + 1;
      chk("retired", retired, exp_ret);
      chk("back_fetch", 32'(state), 32'd1);
    end
  endtask

  logic [5:0] op_tab [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010,
                              6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111};
  logic [5:0] fn_tab [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(obs_vec), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_hold", 32'(state), 32'd0);
    @(posedge clk); #1;
    chk("first_fetch", 32'(state), 32'd1);

    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);   // lw
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);   // slt
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);   // bne not taken
    run_instr(6'b101011, 6'b000000, 1'b0, 3, 2);   // sw with waits
    run_instr(6'b001100, 6'b000000, 1'b0, 0, 0);   // andi
    run_instr(6'b001111, 6'b000000, 1'b0, 0, 0);   // lui
    run_instr(6'b001101, 6'b000000, 1'b0, 1, 0);   // ori
    run_instr(6'b001010, 6'b000000, 1'b0, 0, 0);   // slti
    run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);   // addi
    run_instr(6'b000010, 6'b000000, 1'b0, 2, 0);   // j
    run_instr(6'b000000, 6'b100111, 1'b0, 0, 0);   // nor
    run_instr(6'b100011, 6'b000000, 1'b0, 2, 3);   // lw with waits
    if (!TRAP_EN) begin
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
      run_instr(6'b000000, 6'b000001, 1'b0, 1, 0);
    end

    for (int n = 0; n < 200; n++) begin
      op = op_tab[$urandom_range(0, 10)];
      fn = fn_tab[$urandom_range(0, 5)];
      if (!TRAP_EN && $urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) op = 6'b110011;
        else begin op = 6'b000000; fn = 6'b000000; end
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset asserted while a load waits in MEMRD
    opcode = 6'b100011; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    #1 chk("memrd_wait", 32'(state), 32'd4);
    chk("memrd_read", 32'(mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_ctrl", 32'(obs_vec), 32'd0);
    chk("async_retired", retired, 32'd0);
    exp_ret = '0;
    @(posedge clk); #1;
    chk("rst_held", 32'(state), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_fetch", 32'(state), 32'd1);
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);

    if (TRAP_EN) begin
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
      for (int k = 0; k < 20; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #4;
        chk("trap_state", 32'(state), 32'd13);
        chk("trap_illegal", 32'(illegal), 32'd1);
        chk("trap_ctrl", 32'(obs_vec), 32'd0);
        chk("trap_retired", retired, exp_ret);
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore FSM control unit for the multicycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback per instruction.
- Drives the register file, ALU, memory and PC muxes, plus the immediate extender mode (sign/zero/LUI).
- Handshakes with a variable-latency memory and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address mux: 0=PC, 1=ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC load enable (branch condition resolved internally)
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm, 11=ext imm<<2
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- ext_mode  out  2  00=sign-extend, 01=zero-extend, 10=imm<<16
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  sticky illegal-instruction flag
- state  out  4  current state encoding, for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12, TRAP=13.
- Async reset: state=RST, retired=0, illegal=0. In RST every output is 0. RST always goes to FETCH on the next edge.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_source=00.
  - Holds while mem_ready=0.
  - ir_write and pc_en are 1 only in the cycle mem_ready=1; the FSM then moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Dispatch on opcode:
  - 000000 -> EXEC
  - 100011 (lw), 101011 (sw) -> MEMADR
  - 000100 (beq), 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000, 001100, 001101, 001010, 001111 -> IEXEC
  - else -> illegal path (see Optional Feature)
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR. Unknown funct uses the illegal path instead of EXEC.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01. pc_en = zero for beq, !zero for bne (combinational).
- JUMP: pc_source=10, pc_en=1.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_ctrl: addi ADD, andi AND, ori OR, slti SLT, lui OR (with reg A = $zero per ISA).
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0.
- ext_mode (all non-RST states, decoded from opcode): andi/ori -> 01; lui -> 10; everything else -> 00.
- Terminal states assert instr_done and return to FETCH: MEMWB, MEMWR (on mem_ready), RWB, BRANCH, JUMP, IWB.
- retired increments when instr_done=1 and wraps at 2^CNT_W-1 -> 0.
- Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, I-type ALU 4, beq/bne 3, j 3. Each mem_ready=0 cycle adds one cycle.
- mem_read/mem_write stay asserted and stable throughout a wait. An address (i_or_d) never changes mid-access.
- Reset mid-instruction: immediate return to RST, all outputs 0, counter cleared. No partial writes after the reset edge.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode or funct goes from DECODE to TRAP.
  - illegal=1 (sticky until reset); all other outputs 0.
  - TRAP never exits; no instr_done; retired frozen.
- Undefined: an illegal instruction is a NOP. DECODE -> FETCH with instr_done=1, retired increments, and illegal stays 0 permanently.

Test Plan:
- Reset release, opcode=100011 (lw), mem_ready=1 -> states 0,1,2,3,4,5,1. ext_mode=00. reg_write+mem_to_reg only in MEMWB. retired=1.
- R-type opcode=000000, funct=101010 -> alu_ctrl=0111 in EXEC. reg_dst=1, reg_write=1 in RWB. 4 cycles from FETCH to instr_done.
- beq with zero=1 -> pc_en=1, pc_source=01 in BRANCH. bne with zero=1 -> pc_en=0. Both take 3 cycles.
- sw with mem_ready low 3 cycles in FETCH and 2 in MEMWR -> mem_read/mem_write held stable. ir_write pulses exactly once. instr_done after 9 cycles.
- andi (001100) -> ext_mode=01; lui (001111) -> ext_mode=10. alu_ctrl=0000 and 0001 respectively in IEXEC.
- opcode=111111 -> with macro: state=13, illegal=1, retired unchanged for 20 cycles. Without macro: back to FETCH, retired+1. Assert rst_n=0 mid-MEMRD -> all outputs 0 asynchronously.
